// File: rtl/acc_stream_feeder_pkg.sv
// Shared types and default widths for the accumulator stream feeder.
package acc_stream_feeder_pkg;

    localparam int IN_DATA_WIDTH_DEF = 8;
    localparam int AWIDTH_DEF        = 8;
    localparam int DWIDTH_DEF        = 16;
    localparam int MEM_DEPTH         = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } feeder_state_e;

endpackage

// File: rtl/acc_stream_addr_gen.sv
// Base/count latch and read counter; produces the wrapping read address and last-read flag.
module acc_stream_addr_gen
    import acc_stream_feeder_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [AWIDTH-1:0] base_i,
    input  logic [AWIDTH:0]   cnt_i,
    input  logic              step_i,
    output logic [AWIDTH-1:0] addr_o,
    output logic              last_o,
    output logic              zero_o
);

    logic [AWIDTH-1:0] base_q, base_d;
    logic [AWIDTH:0]   cnt_q, cnt_d;
    logic [AWIDTH-1:0] k_q, k_d;

    always_comb begin
        base_d = base_q;
        cnt_d  = cnt_q;
        k_d    = k_q;
        if (load_i) begin
            base_d = base_i;
            cnt_d  = cnt_i;
            k_d    = '0;
        end else if (step_i) begin
            k_d = k_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            cnt_q  <= '0;
            k_q    <= '0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
            k_q    <= k_d;
        end
    end

    // Address arithmetic is AWIDTH bits wide so base+k wraps naturally.
    assign addr_o = base_q + k_q;
    assign last_o = ({1'b0, k_q} == (cnt_q - 1'b1));
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/acc_stream_feeder.sv
// Feeder FSM: clears the accumulator, streams N memory words into it, captures the final sum.
module acc_stream_feeder
    import acc_stream_feeder_pkg::*;
#(
    parameter int IN_DATA_WIDTH = IN_DATA_WIDTH_DEF,
    parameter int DWIDTH        = DWIDTH_DEF,
    parameter int AWIDTH        = AWIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [AWIDTH-1:0]        base_addr_i,
    input  logic [AWIDTH:0]          num_cnt_i,
    output logic                     idle_o,
    output logic                     running_o,
    output logic                     done_o,
    output logic [DWIDTH-1:0]        result_o,
    output logic [AWIDTH-1:0]        mem_addr_o,
    output logic                     mem_ce_o,
    input  logic [IN_DATA_WIDTH-1:0] mem_q_i,
    output logic                     acc_run_o,
    output logic                     acc_valid_o,
    output logic [IN_DATA_WIDTH-1:0] acc_number_o,
    input  logic                     acc_valid_i,
    input  logic [DWIDTH-1:0]        acc_result_i
);

    feeder_state_e     state_q, state_d;
    logic [DWIDTH-1:0] result_q, result_d;
    logic              acc_vld_out_q;
    logic              acc_vld_in_q;

    logic              load;
    logic              step;
    logic [AWIDTH-1:0] gen_addr;
    logic              gen_last;
    logic              gen_zero;

    acc_stream_addr_gen #(.AWIDTH(AWIDTH)) u_addr_gen (
        .clk    (clk),
        .rst    (reset),
        .load_i (load),
        .base_i (base_addr_i),
        .cnt_i  (num_cnt_i),
        .step_i (step),
        .addr_o (gen_addr),
        .last_o (gen_last),
        .zero_o (gen_zero)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        load      = 1'b0;
        step      = 1'b0;
        acc_run_o = 1'b0;
        mem_ce_o  = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                acc_run_o = 1'b1;
                if (gen_zero) begin
                    result_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                mem_ce_o = 1'b1;
                step     = 1'b1;
                if (gen_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Falling edge of the accumulator's valid marks the final sum.
                if (acc_vld_in_q && !acc_valid_i) begin
                    result_d = acc_result_i;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            result_q      <= '0;
            acc_vld_out_q <= 1'b0;
            acc_vld_in_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            result_q      <= result_d;
            acc_vld_out_q <= mem_ce_o;
            acc_vld_in_q  <= acc_valid_i;
        end
    end

    assign idle_o      = (state_q == ST_IDLE);
    assign running_o   = (state_q == ST_CLEAR) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign result_o    = result_q;
    assign mem_addr_o  = mem_ce_o ? gen_addr : '0;
    assign acc_valid_o = acc_vld_out_q;
    // The accumulator adds once more after valid drops; a forced zero keeps that add harmless.
    assign acc_number_o = acc_vld_out_q ? mem_q_i : '0;

endmodule

// File: tb/tb_acc_stream_feeder.sv
// Directed bench for acc_stream_feeder with a sync-read memory and accumulator model.
module tb_acc_stream_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [7:0]  base_addr_i;
    logic [8:0]  num_cnt_i;
    logic        idle_o, running_o, done_o;
    logic [15:0] result_o;
    logic [7:0]  mem_addr_o;
    logic        mem_ce_o;
    logic [7:0]  mem_q_i;
    logic        acc_run_o, acc_valid_o;
    logic [7:0]  acc_number_o;
    logic        acc_valid_i;
    logic [15:0] acc_result_i;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [256];
    logic [15:0] acc_sum;

    always #5 clk = ~clk;

    acc_stream_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .num_cnt_i    (num_cnt_i),
        .idle_o       (idle_o),
        .running_o    (running_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ce_o     (mem_ce_o),
        .mem_q_i      (mem_q_i),
        .acc_run_o    (acc_run_o),
        .acc_valid_o  (acc_valid_o),
        .acc_number_o (acc_number_o),
        .acc_valid_i  (acc_valid_i),
        .acc_result_i (acc_result_i)
    );

    // Sync-read memory: data one cycle after the enable.
    always_ff @(posedge clk) begin
        if (mem_ce_o) mem_q_i <= mem[mem_addr_o];
    end

    // Accumulator: adds every non-clear cycle, valid_o is valid_i delayed one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_sum     <= '0;
            acc_valid_i <= 1'b0;
        end else begin
            acc_valid_i <= acc_valid_o;
            if (acc_run_o) acc_sum <= '0;
            else           acc_sum <= acc_sum + 16'(acc_number_o);
        end
    end
    assign acc_result_i = acc_sum;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Launch a run and follow it cycle by cycle (cycle 1 = first cycle after the start edge).
    task automatic run_op(input string tag, input logic [7:0] base, input int n,
                          input logic [15:0] exp_sum, input int poke_cyc);
        int cyc, run_cyc, run_cnt, first_ce, ce_cnt, addr_bad, done_cyc;
        logic [7:0] ea;
        run_cyc = -1; run_cnt = 0; first_ce = -1; ce_cnt = 0; addr_bad = 0; done_cyc = -1;
        @(negedge clk);
        start_i = 1'b1; base_addr_i = base; num_cnt_i = 9'(n);
        @(posedge clk);
        cyc = 0;
        while (cyc < 400 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start_i = (cyc == poke_cyc);
            if (acc_run_o) begin
                run_cnt++;
                if (run_cyc < 0) run_cyc = cyc;
            end
            if (mem_ce_o) begin
                ea = base + 8'(ce_cnt);
                if (mem_addr_o !== ea) addr_bad++;
                if (first_ce < 0) first_ce = cyc;
                ce_cnt++;
            end
            if (done_o) done_cyc = cyc;
        end
        start_i = 1'b0;
        chk({tag, " run_cycle"}, 32'(run_cyc), 32'd1);
        chk({tag, " run_pulses"}, 32'(run_cnt), 32'd1);
        chk({tag, " reads"}, 32'(ce_cnt), 32'(n));
        if (n > 0) chk({tag, " first_read"}, 32'(first_ce), 32'd2);
        chk({tag, " addr_errs"}, 32'(addr_bad), 32'd0);
        chk({tag, " done_cycle"}, 32'(done_cyc), 32'(n + 5 - (n == 0 ? 3 : 0)));
        chk({tag, " result"}, 32'(result_o), 32'(exp_sum));
        @(negedge clk);
        chk({tag, " idle_after"}, {31'd0, idle_o}, 32'd1);
        chk({tag, " done_pulse"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        int busy;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        start_i = 1'b0; base_addr_i = '0; num_cnt_i = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst idle", {31'd0, idle_o}, 32'd1);
        chk("rst outs", {26'd0, running_o, done_o, mem_ce_o, acc_run_o, acc_valid_o, 1'b0}, 32'd0);
        chk("rst result", 32'(result_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        mem[8'h10] = 8'd1; mem[8'h11] = 8'd2; mem[8'h12] = 8'd3; mem[8'h13] = 8'd4;
        run_op("basic", 8'h10, 4, 16'd10, -1);

        mem[8'hFE] = 8'd5; mem[8'hFF] = 8'd6; mem[8'h00] = 8'd7; mem[8'h01] = 8'd8;
        run_op("wrap", 8'hFE, 4, 16'd26, -1);

        // start pulse in cycle 3 (READ) must be ignored
        run_op("poke", 8'h10, 4, 16'd10, 3);
        busy = 0;
        repeat (5) begin
            @(negedge clk);
            if (running_o) busy++;
        end
        chk("poke no_requeue", 32'(busy), 32'd0);
        mem[8'h00] = 8'd9; mem[8'h01] = 8'd9;
        run_op("second", 8'h00, 2, 16'd18, -1);

        run_op("zero", 8'h40, 0, 16'd0, -1);

        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        run_op("full", 8'h00, 256, 16'hFF00, -1);

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'd1; mem[8'h11] = 8'd2; mem[8'h12] = 8'd3; mem[8'h13] = 8'd4;
        run_op("pre_rst", 8'h10, 4, 16'd10, -1);

        // Reset in the second READ cycle (cycle 3)
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 8'h10; num_cnt_i = 9'd4;
        @(posedge clk);
        @(negedge clk); start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst in_read", {31'd0, mem_ce_o}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst idle", {31'd0, idle_o}, 32'd1);
        chk("midrst strobes", {27'd0, running_o, done_o, mem_ce_o, acc_run_o, acc_valid_o}, 32'd0);
        chk("midrst result", 32'(result_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("post_rst", 8'h10, 4, 16'd10, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_stream_feeder.md
Name: acc_stream_feeder

Overview:
- Initiator-side controller for the accumulator core (run/valid/number interface, 1-cycle latency, 16-bit result).
- On start, clears the accumulator, streams N words from a 256-entry sync-read memory into it, waits for the accumulator to finish, then latches its result and pulses done.
- Sits between the top-level control path and the memory/accumulator pair.

Parameters:
- IN_DATA_WIDTH, 8, width of memory words and of number_o.
- DWIDTH, 16, width of the accumulator result (AWIDTH + IN_DATA_WIDTH).
- AWIDTH, 8, memory address width (256 entries).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- base_addr_i  in  AWIDTH  first read address; captured on accepted start.
- num_cnt_i  in  AWIDTH+1  word count, 0..256; captured on accepted start.
- idle_o  out  1  high in IDLE.
- running_o  out  1  high in CLEAR, READ and DRAIN.
- done_o  out  1  one-cycle pulse when result_o updates.
- result_o  out  DWIDTH  last captured sum; holds until the next done.
- mem_addr_o  out  AWIDTH  memory read address.
- mem_ce_o  out  1  memory read enable.
- mem_q_i  in  IN_DATA_WIDTH  memory read data, valid 1 cycle after mem_ce_o.
- acc_run_o  out  1  accumulator clear.
- acc_valid_o  out  1  accumulator data valid.
- acc_number_o  out  IN_DATA_WIDTH  accumulator operand.
- acc_valid_i  in  1  accumulator valid_o.
- acc_result_i  in  DWIDTH  accumulator result_o.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: all outputs 0 except idle_o = 1. FSM goes to IDLE; counters and latched base/count cleared.
- FSM states: IDLE, CLEAR, READ, DRAIN, DONE.
- IDLE -> CLEAR when start_i = 1.
  - Capture base_addr_i and num_cnt_i.
  - start_i in any other state is ignored and not queued.
- CLEAR, exactly 1 cycle:
  - acc_run_o = 1; read counter k = 0.
  - Next state is READ if count != 0, else DONE.
  - count = 0: no memory reads; result_o = 0.
- READ, exactly count cycles:
  - mem_ce_o = 1; mem_addr_o = (base + k) mod 2^AWIDTH. Wrap-around is legal.
  - Exit to DRAIN after the read with k = count-1.
- Data path:
  - acc_valid_o = mem_ce_o delayed by one register.
  - acc_number_o = mem_q_i when acc_valid_o = 1, else forced to 0.
  - The accumulator adds one extra time in the cycle after valid falls; the forced 0 makes that add harmless. This rule is mandatory.
- DRAIN:
  - Keep a 1-bit registered copy of acc_valid_i.
  - When the registered copy is 1 and acc_valid_i = 0 (falling edge), latch acc_result_i into result_o and go to DONE.
  - No timeout: for count >= 1 the accumulator always produces a falling edge.
- DONE, 1 cycle: done_o = 1, then go to IDLE.
- Latency, count = N >= 1, start sampled at edge 0:
  - acc_run_o in cycle 1.
  - mem_ce_o in cycles 2..N+1.
  - acc_valid_o in cycles 3..N+2.
  - acc_valid_i high in cycles 4..N+3.
  - result latched at the end of cycle N+4; done_o in cycle N+5.
- Latency, N = 0: done_o in cycle 2.
- Width: sum of 256 × 0xFF = 65280 fits DWIDTH; the feeder does no arithmetic on data.
- Reset mid-operation: immediate return to IDLE; all strobes drop in the same cycle; result_o = 0.
- Back-to-back: start_i held high re-triggers on the cycle after DONE (IDLE is entered for 1 cycle first).

Decomposition:
- Shared package: FSM state encoding (IDLE=0, CLEAR=1, READ=2, DRAIN=3, DONE=4), MEM_DEPTH = 256, default widths.
- One natural sub-module, acc_stream_addr_gen: base/count latch, k counter, wrap address, last-read flag.
- FSM and data-path gating stay in the top module.

Test Plan:
- base 0x10, N=4, mem[0x10..0x13] = 1,2,3,4 -> acc_run_o in cycle 1; addresses 0x10..0x13; result_o = 10; done_o in cycle 9.
- base 0xFE, N=4, data 5,6,7,8 -> addresses FE, FF, 00, 01; result_o = 26.
- N=256, all words 0xFF -> 256 reads; result_o = 65280 (0xFF00); done_o in cycle 261.
- N=0 -> one acc_run_o pulse, no mem_ce_o; result_o = 0; done_o in cycle 2.
- start_i pulsed during READ of an N=4 run, then a second run N=2 at base 0 with data 9,9 -> first run unaffected (10); second run result_o = 18, with no carry-over thanks to acc_run_o.
- reset asserted in the 2nd READ cycle -> all outputs 0 and idle_o = 1 asynchronously; a new start after release gives a correct sum.
